// File: rtl/srambank_ctrl_4x256x34.sv
// Request front-end for four 256 x 34 SRAM banks forming a 1024-word memory.
// Requests are decoded onto a shared bank bus in their accept cycle. Read data
// is captured from the selected bank one cycle later and returned in order
// through a small credit-protected response FIFO.
module srambank_ctrl_4x256x34 #(
    parameter int NBANKS    = 4,
    parameter int BAW       = 8,
    parameter int DW        = 34,
    parameter int RSP_DEPTH = 4
) (
    input  logic                              clk,
    input  logic                              reset_n,
    input  logic                              req_valid,
    output logic                              req_ready,
    input  logic                              req_write,
    input  logic [BAW+$clog2(NBANKS)-1:0]     req_addr,
    input  logic [DW-1:0]                     req_wd,
    output logic                              rsp_valid,
    input  logic                              rsp_ready,
    output logic [DW-1:0]                     rsp_data,
    output logic [BAW-1:0]                    bank_ADDRESS,
    output logic [DW-1:0]                     bank_wd,
    output logic [NBANKS-1:0]                 bank_sel,
    output logic                              bank_read,
    output logic                              bank_write,
    input  logic [NBANKS*DW-1:0]              bank_rdata
);

    localparam int SELW = $clog2(NBANKS);
    localparam int AW   = BAW + SELW;
    localparam int CW   = $clog2(RSP_DEPTH + 1);
    localparam int PW   = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;

    logic [CW-1:0]   count;
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic            pend;
    logic [SELW-1:0] pend_bank;
    logic [DW-1:0]   fifo_mem [RSP_DEPTH];

    logic [SELW-1:0] req_bank;
    logic [CW:0]     occupancy;
    logic            acc;
    logic            push;
    logic            pop;
    logic [DW-1:0]   sel_rdata;

    // Pointers wrap at the FIFO depth, which need not be a power of two.
    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == PW'(RSP_DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign req_bank = req_addr[AW-1:BAW];

    // A read in flight already owns a FIFO slot, so it counts against the credit.
    assign occupancy = {1'b0, count} + (CW+1)'(pend);
    assign req_ready = reset_n & (occupancy < (CW+1)'(RSP_DEPTH));
    assign acc       = req_valid & req_ready;

    assign bank_ADDRESS = req_addr[BAW-1:0];
    assign bank_wd      = req_wd;
    assign bank_write   = acc & req_write;
    assign bank_read    = acc & ~req_write;

    // One-hot bank select, only while a request is actually being accepted.
    always_comb begin
        bank_sel = '0;
        for (int i = 0; i < NBANKS; i++) begin
            if (acc && (req_bank == SELW'(i))) begin
                bank_sel[i] = 1'b1;
            end
        end
    end

    // Pick the latched dataout of the bank the pending read went to.
    always_comb begin
        sel_rdata = '0;
        for (int i = 0; i < NBANKS; i++) begin
            if (pend_bank == SELW'(i)) begin
                sel_rdata = bank_rdata[i*DW +: DW];
            end
        end
    end

    assign push      = pend;
    assign rsp_valid = reset_n & (count != '0);
    assign pop       = rsp_valid & rsp_ready;
    assign rsp_data  = rsp_valid ? fifo_mem[rd_ptr] : '0;

    // Pending-read tracking, FIFO pointers and occupancy.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            count  <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            pend   <= 1'b0;
        end else begin
            pend <= acc & ~req_write;
            if (acc && !req_write) begin
                pend_bank <= req_bank;
            end
            if (push) begin
                wr_ptr <= next_ptr(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= next_ptr(rd_ptr);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Response storage is deliberately not reset; only the pointers matter.
    always_ff @(posedge clk) begin
        if (reset_n && push) begin
            fifo_mem[wr_ptr] <= sel_rdata;
        end
    end

endmodule

// File: tb/tb_srambank_ctrl_4x256x34.sv
// Randomized scoreboard bench for srambank_ctrl_4x256x34 with behavioural
// bank models and a flat 1024-word reference memory.
module tb_srambank_ctrl_4x256x34;

    localparam int NBANKS    = 4;
    localparam int BAW       = 8;
    localparam int DW        = 34;
    localparam int RSP_DEPTH = 4;
    localparam int AW        = 10;

    logic                   clk;
    logic                   reset_n;
    logic                   req_valid;
    logic                   req_ready;
    logic                   req_write;
    logic [AW-1:0]          req_addr;
    logic [DW-1:0]          req_wd;
    logic                   rsp_valid;
    logic                   rsp_ready;
    logic [DW-1:0]          rsp_data;
    logic [BAW-1:0]         bank_ADDRESS;
    logic [DW-1:0]          bank_wd;
    logic [NBANKS-1:0]      bank_sel;
    logic                   bank_read;
    logic                   bank_write;
    logic [NBANKS*DW-1:0]   bank_rdata;

    srambank_ctrl_4x256x34 #(
        .NBANKS(NBANKS), .BAW(BAW), .DW(DW), .RSP_DEPTH(RSP_DEPTH)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wd(req_wd),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .bank_ADDRESS(bank_ADDRESS), .bank_wd(bank_wd), .bank_sel(bank_sel),
        .bank_read(bank_read), .bank_write(bank_write), .bank_rdata(bank_rdata)
    );

    typedef struct {
        logic [DW-1:0] data;
        int            cyc;
    } exp_t;

    exp_t          exp_q [$];
    logic [DW-1:0] ref_mem [int];
    int            checks = 0;
    int            passed = 0;
    int            cyc = 0;
    int            acc_reads = 0;
    bit            strict_lat = 0;
    bit            rand_phase = 0;

    logic [DW-1:0] bank_mem [NBANKS][256];
    logic [DW-1:0] bank_dout [NBANKS];
    bit            bank_init = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Cycle counter used for latency measurement.
    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural SRAM banks: write on select+write, latch dataout on select+read.
    always @(posedge clk) begin
        if (!bank_init) begin
            for (int i = 0; i < NBANKS; i++) begin
                for (int j = 0; j < 256; j++) bank_mem[i][j] <= '0;
                bank_dout[i] <= '0;
            end
            bank_init <= 1'b1;
        end else begin
            for (int i = 0; i < NBANKS; i++) begin
                if (bank_sel[i]) begin
                    if (bank_write) bank_mem[i][bank_ADDRESS] <= bank_wd;
                    else if (bank_read) bank_dout[i] <= bank_mem[i][bank_ADDRESS];
                end
            end
        end
    end

    // Concatenate bank dataout buses.
    always_comb begin
        bank_rdata = '0;
        for (int i = 0; i < NBANKS; i++) bank_rdata[i*DW +: DW] = bank_dout[i];
    end

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual === expected) passed++;
        else $display("[TB] FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, actual, expected, cyc);
    endtask

    // Present one request and hold it until accepted (bounded).
    task automatic applyStimulus(input bit wr, input logic [AW-1:0] addr, input logic [DW-1:0] wd, output int stalls);
        bit got;
        got = 0;
        stalls = 0;
        req_valid = 1'b1;
        req_write = wr;
        req_addr  = addr;
        req_wd    = wd;
        while (!got && stalls < 60) begin
            @(negedge clk);
            if (req_ready) got = 1;
            else stalls++;
        end
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        if (!got) checkOutput("accept_timeout", 64'(0), 64'(1));
    endtask

    // Let every outstanding read come back.
    task automatic drainResponses();
        int n;
        n = 0;
        rsp_ready = 1'b1;
        while (exp_q.size() != 0 && n < 40) begin
            @(negedge clk);
            n++;
        end
        checkOutput("drain_empty", 64'(exp_q.size()), 64'(0));
        @(posedge clk);
        #1;
    endtask

    // Scoreboard input side: check the bank bus and update the reference memory.
    always @(negedge clk) begin
        logic [NBANKS-1:0] exp_sel;
        if (!reset_n) begin
            exp_q.delete();
        end else if (req_valid && req_ready) begin
            exp_sel = 4'b0001 << req_addr[9:8];
            checkOutput("bank_sel", 64'(bank_sel), 64'(exp_sel));
            checkOutput("bank_rw", 64'({bank_read, bank_write}), 64'({~req_write, req_write}));
            checkOutput("bank_addr", 64'(bank_ADDRESS), 64'(req_addr[7:0]));
            if (req_write) begin
                checkOutput("bank_wd", 64'(bank_wd), 64'(req_wd));
                ref_mem[int'(req_addr)] = req_wd;
            end else begin
                exp_q.push_back('{ref_mem.exists(int'(req_addr)) ? ref_mem[int'(req_addr)] : '0, cyc});
                acc_reads++;
            end
        end else begin
            checkOutput("bank_idle", 64'({bank_sel, bank_read, bank_write}), 64'(0));
        end
    end

    // Monitor: compare each presented response against the queue head.
    always @(negedge clk) begin
        exp_t e;
        if (!reset_n) begin
            checkOutput("reset_quiet", 64'({req_ready, rsp_valid, rsp_data, bank_sel, bank_read, bank_write}), 64'(0));
        end else if (rsp_valid) begin
            if (exp_q.size() == 0) begin
                checkOutput("spurious_rsp", 64'(rsp_valid), 64'(0));
            end else begin
                checkOutput("rsp_data", 64'(rsp_data), 64'(exp_q[0].data));
                if (rsp_ready) begin
                    e = exp_q.pop_front();
                    if (strict_lat) checkOutput("latency", 64'(cyc - e.cyc), 64'(2));
                    else checkOutput("latency_min", 64'((cyc - e.cyc) >= 2), 64'(1));
                end
            end
        end else begin
            checkOutput("idle_data", 64'(rsp_data), 64'(0));
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int st;
        int base;
        logic [AW-1:0] a;
        logic [DW-1:0] d;

        reset_n   = 1'b0;
        req_valid = 1'b0;
        req_write = 1'b0;
        req_addr  = '0;
        req_wd    = '0;
        rsp_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        reset_n = 1'b1;
        @(negedge clk);
        checkOutput("ready_after_reset", 64'(req_ready), 64'(1));
        checkOutput("empty_after_reset", 64'(rsp_valid), 64'(0));
        @(posedge clk);
        #1;

        $display("[TB] directed write/read across banks");
        strict_lat = 1;
        applyStimulus(1, 10'h000, 34'h3_0000_0001, st);
        applyStimulus(1, 10'h1FF, 34'h2_AAAA_5555, st);
        applyStimulus(1, 10'h3FF, 34'h1_2345_6789, st);
        applyStimulus(0, 10'h000, '0, st);
        applyStimulus(0, 10'h1FF, '0, st);
        applyStimulus(0, 10'h3FF, '0, st);
        drainResponses();

        $display("[TB] back-to-back reads");
        for (int k = 0; k < 16; k++) applyStimulus(1, AW'(k), {2'(k), 32'($urandom)}, st);
        for (int k = 0; k < 16; k++) begin
            applyStimulus(0, AW'(k), '0, st);
            checkOutput("b2b_no_stall", 64'(st), 64'(0));
        end
        drainResponses();

        $display("[TB] read/write hazards");
        applyStimulus(1, 10'h2A0, 34'h155, st);
        applyStimulus(0, 10'h2A0, '0, st);
        applyStimulus(0, 10'h2A0, '0, st);
        applyStimulus(1, 10'h2A0, 34'h0AA, st);
        applyStimulus(0, 10'h2A0, '0, st);
        drainResponses();
        strict_lat = 0;

        $display("[TB] backpressure");
        rsp_ready = 1'b0;
        base = acc_reads;
        fork
            begin
                int s2;
                for (int k = 0; k < 6; k++) applyStimulus(0, AW'(10'h100 + k), '0, s2);
            end
        join_none
        repeat (8) @(posedge clk);
        @(negedge clk);
        checkOutput("bp_accepted", 64'(acc_reads - base), 64'(4));
        checkOutput("bp_ready_low", 64'(req_ready), 64'(0));
        checkOutput("bp_queued", 64'(exp_q.size()), 64'(4));
        @(posedge clk);
        #1;
        rsp_ready = 1'b1;
        wait fork;
        checkOutput("bp_all_accepted", 64'(acc_reads - base), 64'(6));
        drainResponses();

        $display("[TB] reset with queued reads");
        rsp_ready = 1'b0;
        applyStimulus(0, 10'h001, '0, st);
        applyStimulus(0, 10'h002, '0, st);
        @(posedge clk);
        #1;
        reset_n   = 1'b0;
        req_valid = 1'b1;
        req_write = 1'b0;
        req_addr  = 10'h003;
        @(negedge clk);
        checkOutput("rst_rsp_valid", 64'(rsp_valid), 64'(0));
        checkOutput("rst_rsp_data", 64'(rsp_data), 64'(0));
        checkOutput("rst_bank_ctl", 64'({bank_sel, bank_read, bank_write}), 64'(0));
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        reset_n   = 1'b1;
        rsp_ready = 1'b1;
        @(negedge clk);
        checkOutput("rel_ready", 64'(req_ready), 64'(1));
        checkOutput("rel_no_rsp", 64'(rsp_valid), 64'(0));
        repeat (6) @(negedge clk);
        checkOutput("rel_queue_empty", 64'(exp_q.size()), 64'(0));
        @(posedge clk);
        #1;

        $display("[TB] randomized traffic");
        rand_phase = 1;
        fork
            begin
                while (rand_phase) begin
                    @(posedge clk);
                    #1;
                    rsp_ready = ($urandom_range(0, 3) != 0);
                end
            end
        join_none
        for (int k = 0; k < 300; k++) begin
            if ($urandom_range(0, 1) == 1) a = {2'($urandom_range(0, 3)), 6'b0, 2'($urandom_range(0, 3))};
            else a = AW'($urandom);
            d = {2'($urandom_range(0, 3)), 32'($urandom)};
            applyStimulus($urandom_range(0, 2) == 0, a, d, st);
            if ($urandom_range(0, 3) == 0) begin
                repeat ($urandom_range(1, 2)) @(posedge clk);
                #1;
            end
        end
        rand_phase = 0;
        repeat (2) @(posedge clk);
        #2;
        drainResponses();

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/srambank_ctrl_4x256x34.md
# srambank_ctrl_4x256x34

Request front-end for a group of four `srambank_64x4x34_6t122` banks, giving a 1024 x 34-bit synchronous memory. It accepts read/write requests on a valid/ready port and decodes the 10-bit word address into a bank select plus an 8-bit bank address. It drives the shared bank control/data buses and captures the selected bank's latched `dataout`. Read data returns in order through a small response FIFO with a valid/ready handshake. It sits directly upstream of the banks and is the only master of their inputs.

## Interface
- `NBANKS`, 4, number of banks driven; power of two.
- `BAW`, 8, bank address width (256 words per bank).
- `DW`, 34, data width.
- `RSP_DEPTH`, 4, response FIFO entries; must be ≥3 for full read throughput.
- `clk` in 1, single clock; all state updates on its rising edge.
- `reset_n` in 1, reset, synchronous, active-low.
- `req_valid` in 1, request present.
- `req_ready` out 1, request accepted on a cycle where `req_valid & req_ready`.
- `req_write` in 1, 1 = write, 0 = read.
- `req_addr` in `BAW+log2(NBANKS)` (10), word address; top 2 bits select the bank, low 8 bits are the bank address.
- `req_wd` in `DW`, write data.
- `rsp_valid` out 1, read data available.
- `rsp_ready` in 1, consumer takes the data on `rsp_valid & rsp_ready`.
- `rsp_data` out `DW`, read data; forced to 0 while `rsp_valid`=0.
- `bank_ADDRESS` out `BAW`, shared bank address = `req_addr[7:0]`.
- `bank_wd` out `DW`, shared write data = `req_wd`.
- `bank_sel` out `NBANKS`, one-hot `banksel` per bank.
- `bank_read` out 1, shared `read`.
- `bank_write` out 1, shared `write`.
- `bank_rdata` in `NBANKS*DW`, concatenated bank `dataout`; bank i occupies bits `[i*DW +: DW]`.

## Operation
- Acceptance (`acc = req_valid & req_ready`) drives the bank bus combinationally in the same cycle:
  - `bank_sel` = onehot(`req_addr[9:8]`);
  - `bank_write` = `req_write`;
  - `bank_read` = ~`req_write`.
  - When `acc`=0, `bank_sel`, `bank_read` and `bank_write` are all 0.
- Never assert `bank_read` and `bank_write` together.
- A read accepted in cycle c sets registers `pend`=1 and `pend_bank`=`req_addr[9:8]` at the end of c.
- In cycle c+1, with `pend`=1, the controller pushes `bank_rdata[pend_bank]` into the FIFO at the end of c+1.
- Writes produce no response.
- Credit flow control: `req_ready` = `reset_n` & (`count` + `pend` < `RSP_DEPTH`), where `count` is the current FIFO occupancy.
  - `req_ready` does not depend on `req_valid` or `req_write`.
  - The FIFO therefore never overflows.
- FIFO: circular, `RSP_DEPTH` entries, pointers wrap modulo depth; `count` has width clog2(`RSP_DEPTH`+1).
  - Push and pop in the same cycle leave `count` unchanged.
  - Pop occurs only when `count`>0.
  - `rsp_valid` = (`count`≠0).
- Ordering: responses return in request order.
- Hazards:
  - Read after write to the same address in the next cycle returns the new data.
  - Write issued while a read to the same bank is pending does not corrupt the pending read, because bank `dataout` updates only on reads.
- Reset (`reset_n`=0 at an edge) clears `count`, both pointers and `pend`; FIFO storage is not reset.
  - While `reset_n`=0: `req_ready`=0, bank controls are 0, `rsp_valid`=0, `rsp_data`=0.
  - Reset mid-operation discards pending reads and queued responses; bank contents are untouched.

## Timing
- Read latency: accepted in cycle c → `rsp_valid` first high in cycle c+2 if the FIFO was empty.
- Sustained throughput: 1 read per cycle with `rsp_ready` held high and `RSP_DEPTH`≥3.
- Write takes effect at the end of its accept cycle.
- Backpressure: with `rsp_ready`=0, at most `RSP_DEPTH` reads are accepted; `req_ready` drops in the cycle where `count`+`pend` reaches `RSP_DEPTH`.
- `req_ready` rises the cycle after a pop frees a slot.
- First cycle after `reset_n` rises: `req_ready`=1, FIFO empty.

## Test plan
- Write 0x3_0000_0001 to addr 0x000, 0x2_AAAA_5555 to 0x1FF, 0x1_2345_6789 to 0x3FF; read them back with `rsp_ready`=1 → identical data in order; `bank_sel` 0001/0010/1000; each `rsp_valid` 2 cycles after accept.
- Back-to-back reads of 0x000..0x00F with `rsp_ready`=1 → `req_ready` stays 1; 16 consecutive responses, one per cycle.
- `rsp_ready`=0 while issuing 6 reads → exactly 4 accepted, then `req_ready`=0 and `count`=4.
  - Raise `rsp_ready` → 4 responses in order, then the remaining 2 are accepted.
- Write 0x155 to addr 0x2A0 at cycle c, read 0x2A0 at c+1 → returns 0x155.
  - Read 0x2A0 at c, write 0x0AA at c+1 → returns 0x155.
- Pulse `reset_n`=0 with 2 reads queued → `rsp_valid`=0, `rsp_data`=0, no bank control asserted.
  - After release: `req_ready`=1 and no stale responses appear.
